// File: rtl/pdm_pkg.sv
// Shared defaults and helpers for the PCM-to-PDM output stage.
package pdm_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CLK_DIV    = 32;
  localparam int DEF_OSR        = 64;

  // One extra bit holds the modulator carry, which is the emitted PDM bit.
  function automatic int acc_width(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Two's complement to offset binary: flip the sign bit of a data_width-wide value.
  function automatic logic [31:0] to_offset(input logic [31:0] sample, input int data_width);
    return sample ^ (32'd1 << (data_width - 1));
  endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// Synchronous sample FIFO; pointers carry one extra bit so full and empty are distinguishable.
module pdm_sample_fifo
  import pdm_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == LW'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pdm_sd_modulator.sv
// PCM stream -> FIFO -> first-order sigma-delta -> 1-bit PDM pad at HCLK/CLK_DIV.
// Define PDM_OPEN_DRAIN_EN for an open-drain pad (bit driven through pdm_oe); default is push-pull.
module pdm_sd_modulator
  import pdm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int OSR        = DEF_OSR,
  localparam int LW = level_width(FIFO_DEPTH)
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  en,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [LW-1:0]         fifo_level,
  output logic                  underrun,
  input  logic                  underrun_clr,
  output logic                  pdm_out,
  output logic                  pdm_oe,
  output logic                  amp_sd
);

  localparam int ACC_W = acc_width(DATA_WIDTH);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(OSR);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] sample_reg;
  logic                  first_pending;
  logic                  en_reg;
  logic                  pdm_bit;
  logic                  underrun_reg;

  logic                  pdm_tick;
  logic                  sample_tick;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] u;
  logic [ACC_W-1:0]      acc_sum;

  assign pdm_tick    = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  // The first tick after enable loads a sample so modulation starts from fresh data.
  assign sample_tick = pdm_tick && (first_pending || (bit_cnt == BIT_W'(OSR - 1)));
  assign fifo_push   = s_valid && !fifo_full;
  assign fifo_pop    = sample_tick && !fifo_empty;

  assign u       = DATA_WIDTH'(to_offset(32'(sample_reg), DATA_WIDTH));
  assign acc_sum = ACC_W'(acc) + ACC_W'(u);

  pdm_sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt       <= '0;
      bit_cnt       <= '0;
      acc           <= '0;
      sample_reg    <= '0;
      first_pending <= 1'b1;
      en_reg        <= 1'b0;
      pdm_bit       <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      en_reg <= en;
      if (!en) begin
        div_cnt       <= '0;
        bit_cnt       <= '0;
        acc           <= '0;
        pdm_bit       <= 1'b0;
        first_pending <= 1'b1;
      end else begin
        div_cnt <= pdm_tick ? '0 : div_cnt + DIV_W'(1);
        if (pdm_tick) begin
          bit_cnt       <= sample_tick ? '0 : bit_cnt + BIT_W'(1);
          first_pending <= 1'b0;
          // Accumulator wraps by design; the carry out is the PDM bit.
          {pdm_bit, acc} <= acc_sum;
        end
      end
      if (sample_tick) sample_reg <= fifo_empty ? '0 : fifo_head;
      if (sample_tick && fifo_empty) underrun_reg <= 1'b1;
      else if (underrun_clr)         underrun_reg <= 1'b0;
    end
  end

`ifdef PDM_OPEN_DRAIN_EN
  assign pdm_out = 1'b0;
  assign pdm_oe  = en_reg & ~pdm_bit;
`else
  assign pdm_out = pdm_bit;
  assign pdm_oe  = en_reg;
`endif

  assign amp_sd   = en_reg;
  assign underrun = underrun_reg;
  assign s_ready  = !fifo_full;

endmodule
